// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : Iterative signed Booth multiplier / restoring divider for HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0]       c_IDLE = 3'd0;
    localparam logic [2:0]       c_MULT = 3'd1;
    localparam logic [2:0]       c_DIV  = 3'd2;
    localparam logic [2:0]       c_FIX  = 3'd3;
    localparam logic [2:0]       c_DONE = 3'd4;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    // One guard bit on the accumulator keeps -(most-negative) representable.
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH:0]   r_m;
    logic             r_aNeg;
    logic             r_bNeg;
    logic             r_dzPend;

    logic             w_accept;
    logic             w_bZero;
    logic [WIDTH-1:0] w_aAbs;
    logic [WIDTH-1:0] w_bAbs;
    logic [WIDTH:0]   w_boothSum;
    logic [WIDTH:0]   w_shifted;
    logic             w_ge;
    logic             w_busyNext;
    logic             w_doneNext;
    logic             w_dzNext;
    logic             w_loadResult;

    assign w_accept  = (r_state == c_IDLE) && start && !done;
    assign w_bZero   = (b == '0);
    assign w_aAbs    = a[WIDTH-1] ? -a : a;
    assign w_bAbs    = b[WIDTH-1] ? -b : b;
    assign w_shifted = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_ge      = (w_shifted >= r_m);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    if (!op)          w_stateNext = c_MULT;
                    else if (w_bZero) w_stateNext = c_DONE;
                    else              w_stateNext = c_DIV;
                end
            end
            c_MULT:  w_stateNext = (r_cnt == c_LAST) ? c_DONE : c_MULT;
            c_DIV:   w_stateNext = (r_cnt == c_LAST) ? c_FIX : c_DIV;
            c_FIX:   w_stateNext = c_DONE;
            c_DONE:  w_stateNext = c_IDLE;
            default: w_stateNext = c_IDLE;
        endcase
    end

    always_comb begin
        w_busyNext   = (w_stateNext != c_IDLE) || (r_state == c_DONE);
        w_doneNext   = (r_state == c_DONE);
        w_dzNext     = (r_state == c_DONE) && r_dzPend;
        w_loadResult = (r_state == c_DONE) && !r_dzPend;
    end

    always_comb begin
        case ({r_q[0], r_qm1})
            2'b01:   w_boothSum = r_acc + r_m;
            2'b10:   w_boothSum = r_acc - r_m;
            default: w_boothSum = r_acc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_qm1    <= 1'b0;
            r_m      <= '0;
            r_aNeg   <= 1'b0;
            r_bNeg   <= 1'b0;
            r_dzPend <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_qm1    <= 1'b0;
                        r_aNeg   <= a[WIDTH-1];
                        r_bNeg   <= b[WIDTH-1];
                        r_dzPend <= op && w_bZero;
                        if (op) begin
                            r_q <= w_aAbs;
                            r_m <= {1'b0, w_bAbs};
                        end else begin
                            r_q <= a;
                            r_m <= {b[WIDTH-1], b};
                        end
                    end
                end
                c_MULT: begin
                    r_acc <= {w_boothSum[WIDTH], w_boothSum[WIDTH:1]};
                    r_q   <= {w_boothSum[0], r_q[WIDTH-1:1]};
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + 1'b1;
                end
                c_DIV: begin
                    if (w_ge) begin
                        r_acc <= w_shifted - r_m;
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= w_shifted;
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                // Quotient truncates toward zero; remainder follows the dividend.
                c_FIX: begin
                    r_acc <= {1'b0, r_aNeg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]};
                    r_q   <= (r_aNeg ^ r_bNeg) ? -r_q : r_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            busy     <= w_busyNext;
            done     <= w_doneNext;
            div_zero <= w_dzNext;
            if (w_loadResult) begin
                hi <= r_acc[WIDTH-1:0];
                lo <= r_q;
            end
        end
    end

endmodule
`default_nettype wire
